// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg -- shared AES-128 key-schedule definitions.
//   NB       : words per round key (4)
//   KEY_W    : round-key width in bits (128)
//   RCON     : round constants, indexed by round number (entry 0 unused)
//   ks_state_e : inverse key-schedule controller states; FWD exists only when
//              INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN is defined.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int NB    = 4;
  localparam int KEY_W = 128;

  // Padded to 16 entries so a 4-bit round index can never fall outside it.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

`ifdef INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, EMIT = 2'd2} ks_state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd2} ks_state_e;
`endif

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox -- combinational AES forward S-box.
//   data : byte in
//   sub  : S-box(data)
// Computed as the GF(2^8) multiplicative inverse (x^254, 0 maps to 0)
// followed by the AES affine transform, instead of a 256-entry table.
// -----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  // Multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // NOTE: sq and inv get a value before the loop, so this block is purely
  // combinational with no path that could infer a latch.
  always_comb begin
    sq  = data;
    inv = 8'h01;
    // Accumulates a^2 * a^4 * ... * a^128 = a^254 = a^-1.
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  assign sub = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/inv_key_schedule.sv
// -----------------------------------------------------------------------------
// inv_key_schedule -- AES-128 round-key generator for decryption order.
// Emits round keys Nr..0, one per rk_valid/rk_ready handshake.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   key_in     : key to load, word 0 in [127:96]
//   key_valid  : key_in presented (taken when key_ready is high)
//   key_ready  : high only in IDLE
//   round_key  : current round key, word 0 in [127:96]
//   round_num  : round index of round_key
//   rk_valid   : round_key/round_num valid
//   rk_ready   : consumer takes the current round key
//   done       : one-cycle pulse after round 0 is taken
// Build option INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN: key_in is the cipher key
// and is expanded forward for Nr cycles before emission. Without it, key_in
// is already the round-Nr key and emission starts the next cycle.
// -----------------------------------------------------------------------------
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_num,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             done
);

  if (Nk != NB) begin : g_nk_check
    $error("inv_key_schedule supports only Nk=4");
  end

  localparam logic [3:0] NR4 = 4'(Nr);

  ks_state_e   state;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] sub_src, rot, sub_word, mix;
  logic [7:0]  rcon_byte;
  logic [KEY_W-1:0] prev_key;

  assign {k0, k1, k2, k3} = round_key;
  assign key_ready = (state == IDLE);

`ifdef INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN
  logic             fwd_mode;
  logic [31:0]      n0, n1, n2, n3;
  logic [KEY_W-1:0] fwd_key;

  // The forward step producing round r+1 feeds word 3 of round r to SubWord;
  // the inverse step feeds the recovered p3 = k3^k2 of the earlier round.
  assign fwd_mode  = (state == FWD);
  assign sub_src   = fwd_mode ? k3 : (k3 ^ k2);
  assign rcon_byte = RCON[fwd_mode ? round_num + 4'd1 : round_num];
`else
  assign sub_src   = k3 ^ k2;
  assign rcon_byte = RCON[round_num];
`endif

  assign rot = {sub_src[23:0], sub_src[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data (rot[8*i +: 8]),
      .sub  (sub_word[8*i +: 8])
    );
  end

  // Shared term: both directions XOR word 0 with SubWord(RotWord(.)) ^ Rcon.
  assign mix      = sub_word ^ {rcon_byte, 24'h000000};
  assign prev_key = {k0 ^ mix, k1 ^ k0, k2 ^ k1, k3 ^ k2};

`ifdef INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN
  assign n0      = k0 ^ mix;
  assign n1      = k1 ^ n0;
  assign n2      = k2 ^ n1;
  assign n3      = k3 ^ n2;
  assign fwd_key = {n0, n1, n2, n3};
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // state and data outputs then update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
      round_key <= '0;
      round_num <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            round_key <= key_in;
`ifdef INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN
            round_num <= 4'd0;
            state     <= FWD;
`else
            round_num <= NR4;
            rk_valid  <= 1'b1;
            state     <= EMIT;
`endif
          end
        end
`ifdef INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN
        FWD: begin
          round_key <= fwd_key;
          round_num <= round_num + 4'd1;
          if (round_num == NR4 - 4'd1) begin
            rk_valid <= 1'b1;
            state    <= EMIT;
          end
        end
`endif
        EMIT: begin
          if (rk_ready) begin
            if (round_num == 4'd0) begin
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              round_key <= prev_key;
              round_num <= round_num - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_inv_key_schedule -- self-checking bench for inv_key_schedule.
// Reference: the standard AES-128 word expansion over a 44-word array, run
// forward from the cipher key or backward from the round-10 key depending on
// INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN. Inputs change and outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_r10, got_r9, got_r0;

`ifdef INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN
  localparam int EXP_LAT = 11;
  localparam logic [127:0] DIR_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
  localparam int EXP_LAT = 1;
  localparam logic [127:0] DIR_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`endif

  inv_key_schedule #(.Nk(4), .Nr(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_num (round_num),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Carry-less product then reduction by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] g_word(input logic [31:0] w, input int rnd);
    logic [31:0] r;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 1; i < rnd; i++) rc = gmul(rc, 8'h02);
    r = {w[23:0], w[31:24]};
    return {sbox_t[r[31:24]] ^ rc, sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
`ifdef INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = (i % 4 == 0) ? g_word(w[i-1], i / 4) : w[i-1];
      w[i] = w[i-4] ^ t;
    end
`else
    for (int i = 0; i < 4; i++) w[40+i] = key[127 - 32*i -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = (i % 4 == 0) ? g_word(w[i-1], i / 4) : w[i-1];
      w[i-4] = w[i] ^ t;
    end
`endif
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full key sequence. Called at a falling edge with the DUT idle, unless
  // loaded=1 (key_valid already driven high for the coming edge).
  // abort_round >= 0 asserts reset when that round is on the output.
  // chain=1 leaves key_valid high with chain_key in the done cycle.
  task automatic run_key(input logic [127:0] key, input bit rand_ready, input bit busy,
                         input int abort_round, input bit loaded,
                         input logic [127:0] chain_key, input bit chain);
    int lat, cyc, exp_r;
    build_model(key);
    if (!loaded) begin
      check("key_ready_idle", 128'(key_ready), 128'(1));
      key_in    = key;
      key_valid = 1'b1;
    end
    @(negedge clk);
    key_valid = 1'b0;
    key_in    = rand_key();
    lat = 1;
    while (!rk_valid && lat < 40) begin
      check("key_ready_fwd", 128'(key_ready), 128'(0));
      @(negedge clk);
      lat++;
    end
    check("first_valid_latency", 128'(lat), 128'(EXP_LAT));
    if (!rk_valid) return;

    exp_r = 10;
    cyc   = 0;
    while (exp_r >= 0 && cyc < 300) begin
      check("rk_valid", 128'(rk_valid), 128'(1));
      check("round_num", 128'(round_num), 128'(exp_r));
      check("round_key", round_key, exp_rk[exp_r]);
      check("key_ready_emit", 128'(key_ready), 128'(0));
      check("done_early", 128'(done), 128'(0));
      if (exp_r == 10) got_r10 = round_key;
      if (exp_r == 9)  got_r9  = round_key;
      if (exp_r == 0)  got_r0  = round_key;
      if (exp_r == abort_round) begin
        // Reset must win over a concurrent load and handshake.
        reset     = 1'b1;
        rk_ready  = 1'b1;
        key_valid = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        rk_ready  = 1'b0;
        key_valid = 1'b0;
        check("abort_rk_valid", 128'(rk_valid), 128'(0));
        check("abort_key_ready", 128'(key_ready), 128'(1));
        check("abort_round_key", round_key, 128'(0));
        check("abort_round_num", 128'(round_num), 128'(0));
        for (int i = 0; i < 4; i++) begin
          check("abort_no_done", 128'(done), 128'(0));
          check("abort_no_valid", 128'(rk_valid), 128'(0));
          @(negedge clk);
        end
        return;
      end
      rk_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      key_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      key_in    = rand_key();
      @(negedge clk);
      cyc++;
      if (rk_ready) exp_r--;
    end
    check("emit_within_budget", 128'(exp_r < 0), 128'(1));
    rk_ready  = 1'b0;
    key_valid = 1'b0;
    check("end_rk_valid", 128'(rk_valid), 128'(0));
    check("done_pulse", 128'(done), 128'(1));
    check("key_ready_at_done", 128'(key_ready), 128'(1));
    if (chain) begin
      key_in    = chain_key;
      key_valid = 1'b1;
      return;
    end
    @(negedge clk);
    check("done_one_cycle", 128'(done), 128'(0));
  endtask

  task automatic check_directed();
`ifdef INV_KEY_SCHEDULE_FWD_PRECOMPUTE_EN
    check("dir_round10", got_r10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("dir_final_is_key", got_r0, DIR_KEY);
`else
    check("dir_round9", got_r9, 128'h549932d1f08557681093ed9cbe2c974e);
    check("dir_round0", got_r0, 128'h000102030405060708090a0b0c0d0e0f);
`endif
  endtask

  initial begin
    logic [127:0] k1, k2;
    reset     = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("reset_key_ready", 128'(key_ready), 128'(1));
    check("reset_rk_valid", 128'(rk_valid), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_round_key", round_key, 128'(0));
    check("reset_round_num", 128'(round_num), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed vector at full throughput, then under random backpressure.
    run_key(DIR_KEY, 1'b0, 1'b0, -1, 1'b0, '0, 1'b0);
    check_directed();
    run_key(DIR_KEY, 1'b1, 1'b0, -1, 1'b0, '0, 1'b0);
    check_directed();

    // Random keys, with and without stalls and with loads attempted while busy.
    for (int n = 0; n < 3; n++)
      run_key(rand_key(), 1'b1, 1'b0, -1, 1'b0, '0, 1'b0);
    run_key(rand_key(), 1'b0, 1'b1, -1, 1'b0, '0, 1'b0);
    run_key(rand_key(), 1'b1, 1'b1, -1, 1'b0, '0, 1'b0);

    // Reset while round 5 is on the output.
    run_key(rand_key(), 1'b0, 1'b0, 5, 1'b0, '0, 1'b0);
    run_key(rand_key(), 1'b1, 1'b0, -1, 1'b0, '0, 1'b0);

    // Back-to-back: second key accepted in the done cycle.
    k1 = rand_key();
    k2 = rand_key();
    run_key(k1, 1'b0, 1'b0, -1, 1'b0, k2, 1'b1);
    run_key(k2, 1'b0, 1'b0, -1, 1'b1, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
